ram_dp_pipe: RTL and testbench
==============================

RAM_DP_PIPE -- requirements
Module: ram_dp_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 4: width of the read and write address ports.
REQ-003 Parameter DEPTH, default 12: number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter RD_LATENCY, default 1: cycles from read request to data; legal values are 1 and 2 only.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; asynchronous assertion, active-low (0 = in reset).
REQ-007 wr_enb  input  1  write request, sampled each rising clk.
REQ-008 wr_addr  input  ADDR_WIDTH  write word address.
REQ-009 wr_data  input  DATA_WIDTH  write data.
REQ-010 wr_be  input  DATA_WIDTH/8  byte enables; bit i qualifies wr_data[8i+7:8i].
REQ-011 rd_enb  input  1  read request, sampled each rising clk.
REQ-012 rd_addr  input  ADDR_WIDTH  read word address.
REQ-013 rd_data  output  DATA_WIDTH  read data, meaningful only while rd_valid = 1.
REQ-014 rd_valid  output  1  read-data-valid strobe.
REQ-015 rd_err  output  1  out-of-range read flag, aligned with rd_valid.
REQ-016 wr_err  output  1  out-of-range write flag, one-cycle pulse.

Function
REQ-017 Storage SHALL be DEPTH words of DATA_WIDTH bits, held in flops.
REQ-018 A write SHALL occur when wr_enb = 1 and wr_addr < DEPTH.
- Only the bytes with wr_be[i] = 1 are updated; all other bytes are retained.
- wr_be = 0 leaves the word unchanged and is not an error.
REQ-019 If wr_enb = 1 and wr_addr >= DEPTH:
- memory is unchanged;
- wr_err = 1 in the following cycle, for exactly one cycle.
- Otherwise wr_err = 0.
REQ-020 A read is accepted every cycle rd_enb = 1 (fully pipelined, no backpressure).
- Response appears exactly RD_LATENCY cycles after the sampling edge: rd_valid = 1 with rd_data.
- rd_valid = 0 in all other cycles.
REQ-021 If rd_addr >= DEPTH, the response SHALL be rd_data = 0 with rd_err = 1, in the same cycle as rd_valid; otherwise rd_err = 0.
REQ-022 Same-address collision (read and write both valid, rd_addr == wr_addr, same edge) SHALL be write-first.
- The read returns the old word with the enabled bytes replaced by wr_data.
REQ-023 With RD_LATENCY = 2, a read whose address is written during the second pipeline cycle SHALL still return the value sampled at the request edge (no forwarding into stage 2).
REQ-024 While rd_valid = 0, rd_data SHALL hold its last value; it SHALL NOT toggle on idle cycles.
REQ-025 Reads and writes to different addresses in the same cycle SHALL both complete independently.
REQ-026 A back-to-back read stream of N requests SHALL yield N consecutive rd_valid pulses, in request order.

Reset
REQ-027 While rst = 0, the following SHALL hold, asynchronously on assertion:
- all memory words = 0;
- rd_data = 0, rd_valid = 0, rd_err = 0, wr_err = 0;
- pipeline stages empty.
REQ-028 Reads in flight at reset assertion SHALL be discarded; no rd_valid SHALL appear for them after deassertion.
REQ-029 Requests presented while rst = 0 SHALL be ignored; the first request honoured is the one sampled at the first rising clk with rst = 1.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Byte-enable write: write 0xABCD, be=11 @ addr 3; then write 0x1234, be=01 @ addr 3; then read 3 -> rd_data = 0xAB34, rd_valid after RD_LATENCY.
- Collision: addr 5 holds 0x0000; write 0xBEEF, be=10 @ addr 5 with read addr 5 on the same edge -> rd_data = 0xBE00.
- Out of range (DEPTH=12): write @ addr 13 -> wr_err pulses 1 cycle, memory unchanged; read @ addr 12 -> rd_data = 0, rd_err = 1, rd_valid = 1.
- Streaming: reads of addrs 0..11 on consecutive cycles, RD_LATENCY = 1 and 2 -> 12 contiguous rd_valid pulses, data in order, first pulse at latency 1 and 2 respectively.
- Reset mid-read: RD_LATENCY = 2, rd_enb @ addr 2, then rst = 0 one cycle later -> rd_valid never asserts; after release, all addresses read 0.
- Stage-2 hazard (RD_LATENCY = 2): read addr 7 (holds 0x1111), then write 0x2222 @ addr 7 on the next edge -> rd_data = 0x1111.

Source files
------------

// File: rtl/ram_dp_pipe.sv
// ram_dp_pipe: flop-based simple dual-port RAM with byte enables and a pipelined read path.
//
// Ports:
//   clk_i       single clock, all state updates on the rising edge
//   rst_ni      asynchronous active-low reset; clears memory, pipeline and flags
//   wr_enb_i    write request
//   wr_addr_i   write word address
//   wr_data_i   write data
//   wr_be_i     byte enables, bit i qualifies wr_data_i[8i+7:8i]
//   rd_enb_i    read request (accepted every cycle, no backpressure)
//   rd_addr_i   read word address
//   rd_data_o   read data, valid while rd_valid_o = 1, held otherwise
//   rd_valid_o  read-data-valid strobe, RD_LATENCY cycles after the request edge
//   rd_err_o    out-of-range read flag, aligned with rd_valid_o
//   wr_err_o    out-of-range write flag, one-cycle pulse after the request edge
module ram_dp_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 12,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_enb_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic                    rd_enb_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    output logic                    rd_err_o,
    output logic                    wr_err_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  s1_valid_q;
    logic                  s1_err_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  wr_err_q;

    assign wr_in_range = ({1'b0, wr_addr_i} < DepthW);
    assign rd_in_range = ({1'b0, rd_addr_i} < DepthW);

    // Next memory image with the byte-masked write applied.
    always_comb begin
        mem_d = mem_q;
        if (wr_enb_i && wr_in_range) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_addr_i == ADDR_WIDTH'(i)) begin
                    for (int unsigned b = 0; b < NumBytes; b++) begin
                        if (wr_be_i[b]) begin
                            mem_d[i][8*b +: 8] = wr_data_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Reading from mem_d gives write-first behaviour on a same-address collision.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rd_addr_i == ADDR_WIDTH'(i)) begin
                    rd_word = mem_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_data_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= rd_enb_i;
            s1_err_q   <= rd_enb_i & ~rd_in_range;
            wr_err_q   <= wr_enb_i & ~wr_in_range;
            // Data only moves on a request so it holds across idle cycles.
            if (rd_enb_i) begin
                s1_data_q <= rd_word;
            end
        end
    end

    assign wr_err_o = wr_err_q;

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q;
        logic                  s2_err_q;
        logic [DATA_WIDTH-1:0] s2_data_q;

        // Stage 2 carries the stage-1 snapshot forward; later writes are not forwarded.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s2_valid_q <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_err_q   <= s1_valid_q & s1_err_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rd_valid_o = s2_valid_q;
        assign rd_err_o   = s2_err_q;
        assign rd_data_o  = s2_data_q;
    end else begin : g_lat1
        assign rd_valid_o = s1_valid_q;
        assign rd_err_o   = s1_err_q;
        assign rd_data_o  = s1_data_q;
    end

endmodule

// File: tb/tb_ram_dp_pipe.sv
// tb_ram_dp_pipe: drives one stimulus stream into two ram_dp_pipe instances
// (RD_LATENCY 1 and 2) and checks both against hand-computed expectations.
module tb_ram_dp_pipe;

    logic        clk;
    logic        rst_n;
    logic        wr_enb;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_enb;
    logic [3:0]  rd_addr;

    logic [15:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2;
    logic        rd_err1, rd_err2;
    logic        wr_err1, wr_err2;

    int n_asrt = 0;
    int n_fail = 0;

    ram_dp_pipe #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(1)
    ) u_dut1 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_enb_i  (wr_enb),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .wr_be_i   (wr_be),
        .rd_enb_i  (rd_enb),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data1),
        .rd_valid_o(rd_valid1),
        .rd_err_o  (rd_err1),
        .wr_err_o  (wr_err1)
    );

    ram_dp_pipe #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .RD_LATENCY(2)
    ) u_dut2 (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_enb_i  (wr_enb),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .wr_be_i   (wr_be),
        .rd_enb_i  (rd_enb),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data2),
        .rd_valid_o(rd_valid2),
        .rd_err_o  (rd_err2),
        .wr_err_o  (wr_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic        ev;
        logic [15:0] ed;
        logic        ee;
        logic        ewe;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [15:0] wd, logic [1:0] be,
                                logic re, logic [3:0] ra, logic ev, logic [15:0] ed,
                                logic ee, logic ewe);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.re = re; v.ra = ra;
        v.ev = ev; v.ed = ed; v.ee = ee; v.ewe = ewe;
        return v;
    endfunction

    function automatic logic [15:0] sval(int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_enb = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_enb = 1'b0; rd_addr = '0;
    endtask

    task automatic chk_out(input string tag, input logic v1, input logic [15:0] d1,
                           input logic e1, input logic v2, input logic [15:0] d2,
                           input logic e2);
        chk({tag, " valid1"}, 32'(rd_valid1), 32'(v1));
        chk({tag, " data1"},  32'(rd_data1),  32'(d1));
        chk({tag, " err1"},   32'(rd_err1),   32'(e1));
        chk({tag, " valid2"}, 32'(rd_valid2), 32'(v2));
        chk({tag, " data2"},  32'(rd_data2),  32'(d2));
        chk({tag, " err2"},   32'(rd_err2),   32'(e2));
    endtask

    initial begin
        logic        pv;
        logic [15:0] pd;
        logic        pe;

        //           we wa     wd        be    re ra     ev ed        ee ewe
        vt[0]  = mk(1, 4'd3,  16'hABCD, 2'b11, 0, 4'd0,  0, 16'h0000, 0, 0);
        vt[1]  = mk(1, 4'd3,  16'h1234, 2'b01, 0, 4'd0,  0, 16'h0000, 0, 0);
        vt[2]  = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd3,  1, 16'hAB34, 0, 0);
        vt[3]  = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  0, 16'hAB34, 0, 0);
        vt[4]  = mk(1, 4'd5,  16'hBEEF, 2'b10, 1, 4'd5,  1, 16'hBE00, 0, 0);
        vt[5]  = mk(1, 4'd13, 16'h5555, 2'b11, 1, 4'd5,  1, 16'hBE00, 0, 1);
        vt[6]  = mk(0, 4'd0,  16'h0000, 2'b00, 0, 4'd0,  0, 16'hBE00, 0, 0);
        vt[7]  = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd12, 1, 16'h0000, 1, 0);
        vt[8]  = mk(1, 4'd0,  16'hFFFF, 2'b00, 1, 4'd0,  1, 16'h0000, 0, 0);
        vt[9]  = mk(1, 4'd1,  16'h00FF, 2'b11, 1, 4'd3,  1, 16'hAB34, 0, 0);
        vt[10] = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd1,  1, 16'h00FF, 0, 0);
        vt[11] = mk(1, 4'd15, 16'h1234, 2'b00, 1, 4'd13, 1, 16'h0000, 1, 1);
        vt[12] = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd5,  1, 16'hBE00, 0, 0);
        vt[13] = mk(0, 4'd0,  16'h0000, 2'b00, 1, 4'd1,  1, 16'h00FF, 0, 0);

        // Reset state
        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        chk_out("reset", 0, 16'h0, 0, 0, 16'h0, 0);
        chk("reset wr_err1", 32'(wr_err1), 32'd0);
        chk("reset wr_err2", 32'(wr_err2), 32'd0);
        rst_n = 1'b1;

        // Table: DUT1 shows row k, DUT2 shows row k-1's read result
        pv = 1'b0; pd = 16'h0; pe = 1'b0;
        for (int k = 0; k < 14; k++) begin
            wr_enb = vt[k].we; wr_addr = vt[k].wa; wr_data = vt[k].wd; wr_be = vt[k].be;
            rd_enb = vt[k].re; rd_addr = vt[k].ra;
            cyc();
            chk_out($sformatf("vec%0d", k), vt[k].ev, vt[k].ed, vt[k].ee, pv, pd, pe);
            chk($sformatf("vec%0d wr_err1", k), 32'(wr_err1), 32'(vt[k].ewe));
            chk($sformatf("vec%0d wr_err2", k), 32'(wr_err2), 32'(vt[k].ewe));
            pv = vt[k].ev; pd = vt[k].ed; pe = vt[k].ee;
        end
        idle();
        cyc();
        chk_out("vec_tail", 0, 16'h00FF, 0, pv, pd, pe);
        chk("vec_tail wr_err1", 32'(wr_err1), 32'd0);

        // Streaming: fill 0..11, then read back-to-back
        for (int i = 0; i < 12; i++) begin
            wr_enb = 1'b1; wr_addr = 4'(i); wr_data = sval(i); wr_be = 2'b11;
            cyc();
        end
        idle();
        for (int c = 0; c < 14; c++) begin
            rd_enb = (c < 12);
            rd_addr = 4'(c);
            cyc();
            chk_out($sformatf("stream c%0d", c),
                    c < 12, sval(c < 12 ? c : 11), 0,
                    (c >= 1 && c <= 12), (c == 0) ? 16'h00FF : sval(c - 1 < 12 ? c - 1 : 11), 0);
        end
        idle();

        // Stage-2 hazard: write on the edge after the request must not leak into DUT2
        wr_enb = 1'b1; wr_addr = 4'd7; wr_data = 16'h1111; wr_be = 2'b11;
        cyc();
        idle();
        rd_enb = 1'b1; rd_addr = 4'd7;
        cyc();
        chk("hazard valid1", 32'(rd_valid1), 32'd1);
        chk("hazard data1", 32'(rd_data1), 32'h1111);
        idle();
        wr_enb = 1'b1; wr_addr = 4'd7; wr_data = 16'h2222; wr_be = 2'b11;
        cyc();
        chk("hazard valid2", 32'(rd_valid2), 32'd1);
        chk("hazard data2", 32'(rd_data2), 32'h1111);
        chk("hazard idle valid1", 32'(rd_valid1), 32'd0);
        idle();
        rd_enb = 1'b1; rd_addr = 4'd7;
        cyc();
        chk("hazard reread data1", 32'(rd_data1), 32'h2222);
        chk("hazard late valid2", 32'(rd_valid2), 32'd0);
        chk("hazard hold data2", 32'(rd_data2), 32'h1111);
        idle();
        cyc();
        cyc();

        // Reset mid-read
        rd_enb = 1'b1; rd_addr = 4'd2;
        cyc();
        chk("midrst valid1", 32'(rd_valid1), 32'd1);
        chk("midrst data1", 32'(rd_data1), 32'(sval(2)));
        wr_enb = 1'b1; wr_addr = 4'd13; wr_data = 16'hFFFF; wr_be = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("midrst async", 0, 16'h0, 0, 0, 16'h0, 0);
        cyc();
        chk_out("midrst hold1", 0, 16'h0, 0, 0, 16'h0, 0);
        chk("midrst wr_err1", 32'(wr_err1), 32'd0);
        cyc();
        chk_out("midrst hold2", 0, 16'h0, 0, 0, 16'h0, 0);
        idle();
        rst_n = 1'b1;
        cyc();
        chk_out("midrst post1", 0, 16'h0, 0, 0, 16'h0, 0);
        chk("midrst post wr_err1", 32'(wr_err1), 32'd0);
        chk("midrst post wr_err2", 32'(wr_err2), 32'd0);
        cyc();
        chk_out("midrst post2", 0, 16'h0, 0, 0, 16'h0, 0);
        for (int c = 0; c < 13; c++) begin
            rd_enb = (c < 12);
            rd_addr = 4'(c);
            cyc();
            chk_out($sformatf("cleared c%0d", c), c < 12, 16'h0, 0, (c >= 1), 16'h0, 0);
        end
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
